// File: rtl/data_sram_resp.sv
// Data-side SRAM responder for the MEM stage: byte-lane writes, read-before-write data, range check.
// Optional wait-state sequencer with stallreq is compiled in when DSRAM_WAIT_EN is defined.
`timescale 1ns/1ps
`default_nettype none

module data_sram_resp #(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        err,
  output logic        stallreq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

`ifdef DSRAM_WAIT_EN
  localparam logic [3:0] W = 4'(WAIT_CYC);
`else
  localparam logic [3:0] W = 4'd0;
`endif

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic              out_of_range;
  logic [3:0]        lane_we;
  logic [31:0]       rd_word_reg;
  logic              oor_reg;
  logic [31:0]       hold_reg;
  logic [31:0]       resp_word;
  logic              unused_bits;

  logic [31:0] mem_array [0:(1<<ADDR_W)-1];

  // WAIT ignores en: upstream keeps the request parked under stallreq.
  assign accept       = data_sram_en && (state_reg != WAIT);
  assign word_idx     = data_sram_addr[ADDR_W+1:2];
  assign out_of_range = |data_sram_addr[31:ADDR_W+2];
  assign unused_bits  = ^{data_sram_addr[1:0], 4'(WAIT_CYC)};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = accept && !out_of_range && data_sram_wen[gi];
    end
  endgenerate

  // Read-first port: a store returns the word as it was before the write.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_reg <= mem_array[word_idx];
    end
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem_array[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign resp_word = oor_reg ? 32'd0 : rd_word_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oor_reg  <= 1'b0;
      hold_reg <= 32'd0;
    end else begin
      if (accept) begin
        oor_reg <= out_of_range;
      end
      if (state_reg == RESP) begin
        hold_reg <= resp_word;
      end
    end
  end

  // rdata only changes in RESP, so a read sampled early is not exposed during WAIT.
  assign resp_valid      = (state_reg == RESP);
  assign data_sram_rdata = resp_valid ? resp_word : hold_reg;
  assign err             = resp_valid && oor_reg;

`ifdef DSRAM_WAIT_EN
  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (accept) begin
      cnt_next = W;
    end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
      cnt_next = cnt_reg - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= 4'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign stallreq = (accept && W != 4'd0) || (state_reg == WAIT && cnt_reg > 4'd1);
`else
  assign stallreq = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (data_sram_en) begin
          state_next = (W == 4'd0) ? RESP : WAIT;
        end
      end
      RESP: begin
        if (data_sram_en) begin
          state_next = (W == 4'd0) ? RESP : WAIT;
        end else begin
          state_next = IDLE;
        end
      end
`ifdef DSRAM_WAIT_EN
      WAIT: begin
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: expected responses queued at issue, checked on resp_valid.
// Adapts its wait-state expectations to whether DSRAM_WAIT_EN is defined.
`timescale 1ns/1ps

module tb_data_sram_resp;

  localparam int AW = 12;
  localparam int WC = 3;
`ifdef DSRAM_WAIT_EN
  localparam int W = WC;
`else
  localparam int W = 0;
`endif

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        resp_valid;
  logic        err;
  logic        stallreq;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          known;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model[int];
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [31:0] last_data;
  bit          last_known;
  exp_t        mon_e;

  data_sram_resp #(.ADDR_W(AW), .WAIT_CYC(WC)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .resp_valid      (resp_valid),
    .err             (err),
    .stallreq        (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every resp_valid.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      last_data  = 32'd0;
      last_known = 1'b1;
    end else if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_resp", 32'(resp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(mon_e.due));
        chk("resp_err", 32'(err), 32'(mon_e.err));
        if (mon_e.known) chk("resp_data", data_sram_rdata, mon_e.data);
        last_data  = mon_e.data;
        last_known = mon_e.known;
        $display("resp cyc=%0d rdata=0x%08h err=%0d", cyc, data_sram_rdata, err);
      end
    end else begin
      chk("err_idle", 32'(err), 32'd0);
    end
  end

  // Caller is 1ns after the edge opening cycle T; returns 1ns after the edge opening T+1+W.
  task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                     input bit chk_stall, input bit toggle);
    exp_t        e;
    int          key;
    logic [31:0] w;
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    e.due   = cyc + 1 + W;
    e.known = 1'b1;
    e.err   = 1'b0;
    e.data  = 32'd0;
    if (addr[31:AW+2] != '0) begin
      e.err = 1'b1;
    end else begin
      key = int'(addr[AW+1:2]);
      if (model.exists(key)) begin
        e.data = model[key];
        w = model[key];
        for (int i = 0; i < 4; i++) if (wen[i]) w[8*i +: 8] = wd[8*i +: 8];
        model[key] = w;
      end else begin
        e.known = 1'b0;
        if (wen == 4'hF) model[key] = wd;
      end
    end
    exp_q.push_back(e);
    $display("req  cyc=%0d wen=%h addr=0x%08h wdata=0x%08h", cyc, wen, addr, wd);
    @(negedge clk);
    if (chk_stall) chk("stall_T", 32'(stallreq), 32'(W > 0));
    @(posedge clk); #1;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (chk_stall) chk("stall_wait", 32'(stallreq), 32'(k < W));
      @(posedge clk); #1;
      data_sram_en    = toggle && (k < W) && k[0];
      data_sram_wen   = 4'hF;
      data_sram_addr  = 32'h40;
      data_sram_wdata = $urandom;
    end
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'd0;
    data_sram_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", data_sram_rdata, 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stallreq), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;

    // full-word write then read-back
    req(4'hF, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0);
    req(4'h0, 32'h40, 32'h0, 1'b0, 1'b0);
    // byte lanes 0 and 2
    req(4'hF, 32'h40, 32'h11223344, 1'b0, 1'b0);
    req(4'b0101, 32'h40, 32'hAABBCCDD, 1'b0, 1'b0);
    req(4'h0, 32'h40, 32'h0, 1'b0, 1'b0);
    // out of range aliases word 0 but must not touch it
    req(4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
    req(4'hF, 32'h4000, 32'h55555555, 1'b0, 1'b0);
    req(4'h0, 32'h4000, 32'h0, 1'b0, 1'b0);
    req(4'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // stall window and RESP-cycle levels
    req(4'h0, 32'h40, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("stall_resp", 32'(stallreq), 32'd0);
    chk("valid_resp", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    // en toggling during WAIT must be ignored
    req(4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    req(4'h0, 32'h40, 32'h0, 1'b0, 1'b0);

    // back-to-back mixed traffic
    for (int i = 0; i < 8; i++) req(4'hF, 32'h200 + 32'(i * 4), $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++)
      req(4'($urandom_range(0, 15)), 32'h200 + 32'($urandom_range(0, 7) * 4), $urandom, 1'b0, 1'b0);

    // rdata holds after the response
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_valid", 32'(resp_valid), 32'd0);
    if (last_known) chk("rdata_hold", data_sram_rdata, last_data);
    @(posedge clk); #1;

    // reset during the wait of a store
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = 32'h80;
    data_sram_wdata = 32'h7700_1234;
    model[32] = 32'h7700_1234;
    exp_q.push_back('{data: 32'd0, err: 1'b0, known: 1'b0, due: cyc + 1 + W});
    @(posedge clk); #1;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("midrst_rdata", data_sram_rdata, 32'd0);
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_stall", 32'(stallreq), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 32'(resp_valid), 32'd0);
    chk("postrst_stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    req(4'h0, 32'h80, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
